playfield_memory: RTL and testbench
===================================

# playfield_memory

Parametrised Tetris playfield store: holds one occupancy bit per cell of a `MEM_WIDTH` × `MEM_HEIGHT` grid and merges a landed four-cell piece into it on `write_mem`. After each merge it runs a sequential full-row scan and clear, shifting rows down, and reports the number of lines removed. A collision-query port lets the piece-movement logic test a candidate placement. It sits between the piece controller, which supplies coordinates and `write_mem`, and the display/score logic, which consumes `field`, `done` and `lines_cleared`.

## Interface
- `MEM_WIDTH`, 10, columns.
- `MEM_HEIGHT`, 20, rows; row 0 is top.
- `WIDTH`, 8, bits per coordinate.
- `SCORE_W`, 16, width of total-lines counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `new_rho_x`, `new_rho_y` in 4*WIDTH: landed piece cells; cell k at `[WIDTH*(4-k)-1 -: WIDTH]` (cell 0 in MSBs).
- `write_mem` in 1: merge request.
- `qry_rho_x`, `qry_rho_y` in 4*WIDTH: candidate piece, same packing.
- `clear_field` in 1: synchronous field/score wipe.
- `collision` out 1: candidate overlaps occupied or out-of-range cell (combinational).
- `busy` out 1: merge/scan in progress.
- `done` out 1: one-cycle pulse at end of scan.
- `lines_cleared` out 3: rows removed by last merge (0–4), valid from `done`.
- `total_lines` out SCORE_W: saturating count of all cleared rows.
- `overlap` out 1: sticky; a merge hit an occupied cell (game over).
- `field` out MEM_WIDTH*MEM_HEIGHT: occupancy; cell (i,j) at bit SIZE-1-(MEM_WIDTH*j+i), so MSB is (0,0) and bit 0 is (MEM_WIDTH-1, MEM_HEIGHT-1).

## Operation
- FSM states: IDLE, SCAN, SHIFT.
- IDLE + `write_mem`: OR all four cells into `field`; cells with x≥MEM_WIDTH or y≥MEM_HEIGHT are dropped. If any in-range cell is already set, set `overlap`. Then row pointer ← MEM_HEIGHT-1, go to SCAN, `lines_cleared` ← 0.
- SCAN: if row full → SHIFT (pointer held). Else if pointer = 0 → IDLE with `done`=1. Else pointer−1.
- SHIFT (1 cycle): rows 1..pointer take the row above, row 0 ← 0; `lines_cleared`+1; `total_lines`+1 saturating at all-ones; → SCAN on same row.
- `write_mem` outside IDLE is ignored; no queueing.
- `collision`: any query cell out of range or on a set bit of `field`; evaluated against current `field` in every state. The upstream controller does not issue moves while `busy`.
- `clear_field`: highest priority, any state. Zeroes `field`, `lines_cleared`, `total_lines`, `overlap`; → IDLE, no `done`.
- Duplicate coordinates within one piece are harmless (OR merge); they do not set `overlap` against themselves.

## Timing
- Reset values: `field`=0, state IDLE, `busy`=0, `done`=0, `lines_cleared`=0, `total_lines`=0, `overlap`=0.
- Merge visible on `field` the cycle after the `write_mem` edge; `busy`=1 from that cycle.
- Busy duration = MEM_HEIGHT + 2·k cycles for k cleared rows; `done` and `busy`=0 in the following cycle.
- `busy` is state≠IDLE (registered state, no combinational path from inputs).
- Reset asserted mid-scan aborts immediately; partially shifted field is discarded to 0.

## Structure
- Shared package `tetris_pkg`: cell-index function (i,j)→bit, piece-coordinate unpack helper, FSM state enum.
- One sub-module `row_full_check`: MEM_WIDTH-bit row in → full flag, reused by SCAN mux output.
- The remaining logic (merge, shift, counters, query) is in `playfield_memory`.

## Test plan
- Reset, then `write_mem` with cells (0,5),(1,5),(2,5),(3,5) at MEM_HEIGHT=6 → four bits set, `done` after 6 busy cycles, `lines_cleared`=0.
- Fill row 5 columns 4–9 beforehand, drop I piece into columns 0–3 of row 5 → row 5 cleared, row 4 content moves to 5, `lines_cleared`=1, busy 8 cycles.
- Four-row clear with rows 2–5 pre-filled except column 0 and a vertical I at x=0, y=2..5 → `lines_cleared`=4, `total_lines`=4, field all 0.
- Query with x=10 (MEM_WIDTH=10) → `collision`=1; query on empty cells → 0; query on a set cell → 1.
- Merge onto an occupied cell → `overlap`=1 sticky until `clear_field`; `write_mem` during `busy` → field unchanged.
- Assert `rst` during SHIFT → all outputs at reset values the same cycle; `clear_field` during SCAN → IDLE next cycle with no `done`.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types and helpers for the tetris playfield store
package tetris_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT} state_t;

  // Cell (i,j) maps to a descending bit index so (0,0) sits in the MSB.
  function automatic int cell_bit(input int i, input int j, input int w, input int h);
    return w * h - 1 - (w * j + i);
  endfunction

  // Cell k of a packed piece occupies the k-th field counting down from the MSBs.
  function automatic int piece_coord(input logic [63:0] v, input int k, input int width);
    logic [63:0] s;
    s = (v >> (width * (3 - k))) & ((64'd1 << width) - 64'd1);
    return int'(s[31:0]);
  endfunction

endpackage

// File: rtl/row_full_check.sv
// rtl/row_full_check.sv - flags a playfield row whose every cell is occupied
module row_full_check #(
  parameter int MEM_WIDTH = 10
) (
  input  logic [MEM_WIDTH-1:0] row,
  output logic                 full
);

  assign full = &row;

endmodule

// File: rtl/playfield_memory.sv
// rtl/playfield_memory.sv - playfield occupancy store with piece merge, line clear and collision query
module playfield_memory
  import tetris_pkg::*;
#(
  parameter int MEM_WIDTH  = 10,
  parameter int MEM_HEIGHT = 20,
  parameter int WIDTH      = 8,
  parameter int SCORE_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4*WIDTH-1:0]              new_rho_x,
  input  logic [4*WIDTH-1:0]              new_rho_y,
  input  logic                            write_mem,
  input  logic [4*WIDTH-1:0]              qry_rho_x,
  input  logic [4*WIDTH-1:0]              qry_rho_y,
  input  logic                            clear_field,
  output logic                            collision,
  output logic                            busy,
  output logic                            done,
  output logic [2:0]                      lines_cleared,
  output logic [SCORE_W-1:0]              total_lines,
  output logic                            overlap,
  output logic [MEM_WIDTH*MEM_HEIGHT-1:0] field
);

  localparam int SIZE = MEM_WIDTH * MEM_HEIGHT;
  localparam int RW   = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1;

  state_t            state;
  logic [RW-1:0]     row_ptr;
  logic [MEM_WIDTH-1:0] cur_row;
  logic              row_full;
  logic [SIZE-1:0]   merged;
  logic [SIZE-1:0]   shifted;
  logic              hit;

  assign busy = (state != IDLE);

  always_comb begin
    cur_row = '0;
    for (int r = 0; r < MEM_HEIGHT; r++)
      if (int'(row_ptr) == r) cur_row = field[SIZE-1-MEM_WIDTH*r -: MEM_WIDTH];
  end

  row_full_check #(.MEM_WIDTH(MEM_WIDTH)) u_row_full (
    .row  (cur_row),
    .full (row_full)
  );

  // Overlap is judged against the stored field only, so repeated cells in one piece never self-hit.
  always_comb begin
    merged = field;
    hit    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int x, y;
      x = piece_coord(64'(new_rho_x), k, WIDTH);
      y = piece_coord(64'(new_rho_y), k, WIDTH);
      if (x < MEM_WIDTH && y < MEM_HEIGHT) begin
        if (field[cell_bit(x, y, MEM_WIDTH, MEM_HEIGHT)]) hit = 1'b1;
        merged[cell_bit(x, y, MEM_WIDTH, MEM_HEIGHT)] = 1'b1;
      end
    end
  end

  always_comb begin
    shifted = field;
    for (int r = 1; r < MEM_HEIGHT; r++)
      if (r <= int'(row_ptr))
        shifted[SIZE-1-MEM_WIDTH*r -: MEM_WIDTH] = field[SIZE-1-MEM_WIDTH*(r-1) -: MEM_WIDTH];
    shifted[SIZE-1 -: MEM_WIDTH] = '0;
  end

  always_comb begin
    collision = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int x, y;
      x = piece_coord(64'(qry_rho_x), k, WIDTH);
      y = piece_coord(64'(qry_rho_y), k, WIDTH);
      if (x >= MEM_WIDTH || y >= MEM_HEIGHT) collision = 1'b1;
      else if (field[cell_bit(x, y, MEM_WIDTH, MEM_HEIGHT)]) collision = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row_ptr       <= '0;
      field         <= '0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      overlap       <= 1'b0;
    end else if (clear_field) begin
      state         <= IDLE;
      row_ptr       <= '0;
      field         <= '0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      overlap       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (write_mem) begin
            field         <= merged;
            if (hit) overlap <= 1'b1;
            row_ptr       <= RW'(MEM_HEIGHT - 1);
            lines_cleared <= '0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (row_ptr == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            row_ptr <= row_ptr - 1'b1;
          end
        end
        SHIFT: begin
          // Pointer stays put: the row dropped into place must be rescanned.
          field         <= shifted;
          lines_cleared <= lines_cleared + 3'd1;
          if (total_lines != '1) total_lines <= total_lines + 1'b1;
          state         <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_memory.sv
// tb/tb_playfield_memory.sv - randomized self-checking bench for playfield_memory against a grid model
module tb_playfield_memory;

  localparam int W    = 10;
  localparam int H    = 6;
  localparam int WD   = 8;
  localparam int SW   = 3;
  localparam int SIZE = W * H;
  localparam int SAT  = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4*WD-1:0] new_rho_x = '0, new_rho_y = '0, qry_rho_x = '0, qry_rho_y = '0;
  logic write_mem = 1'b0, clear_field = 1'b0;
  logic collision, busy, done, overlap;
  logic [2:0] lines_cleared;
  logic [SW-1:0] total_lines;
  logic [SIZE-1:0] field;

  int checks = 0;
  int errors = 0;

  bit m_grid [H][W];
  int m_total = 0;
  bit m_overlap = 0;
  int px[4], py[4], qx[4], qy[4];

  playfield_memory #(.MEM_WIDTH(W), .MEM_HEIGHT(H), .WIDTH(WD), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .new_rho_x(new_rho_x), .new_rho_y(new_rho_y), .write_mem(write_mem),
    .qry_rho_x(qry_rho_x), .qry_rho_y(qry_rho_y), .clear_field(clear_field),
    .collision(collision), .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .total_lines(total_lines), .overlap(overlap), .field(field)
  );

  always #5 clk = ~clk;

  function automatic logic [4*WD-1:0] pack(input int v[4]);
    return {WD'(v[0]), WD'(v[1]), WD'(v[2]), WD'(v[3])};
  endfunction

  function automatic logic [SIZE-1:0] model_field();
    logic [SIZE-1:0] f;
    f = '0;
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++)
        f[SIZE-1-(W*j+i)] = m_grid[j][i];
    return f;
  endfunction

  function automatic bit model_collision();
    bit c;
    c = 0;
    for (int k = 0; k < 4; k++)
      if (qx[k] >= W || qy[k] >= H) c = 1;
      else if (m_grid[qy[k]][qx[k]]) c = 1;
    return c;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) m_grid[j][i] = 0;
    m_total = 0;
    m_overlap = 0;
  endtask

  // Merge the piece, then remove full rows by compacting the survivors toward the bottom.
  task automatic model_apply(output logic [SIZE-1:0] mid, output int k);
    bit g [H][W];
    bit ov, full;
    int dst;
    ov = 0;
    for (int c = 0; c < 4; c++)
      if (px[c] < W && py[c] < H && m_grid[py[c]][px[c]]) ov = 1;
    for (int c = 0; c < 4; c++)
      if (px[c] < W && py[c] < H) m_grid[py[c]][px[c]] = 1;
    mid = model_field();
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) g[j][i] = 0;
    dst = H - 1;
    k = 0;
    for (int j = H - 1; j >= 0; j--) begin
      full = 1;
      for (int i = 0; i < W; i++) if (!m_grid[j][i]) full = 0;
      if (full) k++;
      else begin
        for (int i = 0; i < W; i++) g[dst][i] = m_grid[j][i];
        dst--;
      end
    end
    m_grid = g;
    m_total = (m_total + k > SAT) ? SAT : m_total + k;
    if (ov) m_overlap = 1;
  endtask

  task automatic set_piece(input int x0, y0, x1, y1, x2, y2, x3, y3);
    px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1;
    px[2] = x2; py[2] = y2; px[3] = x3; py[3] = y3;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_field = 1'b1;
    @(negedge clk);
    clear_field = 1'b0;
    model_reset();
  endtask

  task automatic do_merge(input bit inject);
    logic [SIZE-1:0] exp_mid;
    int k, cycles;
    model_apply(exp_mid, k);
    @(negedge clk);
    new_rho_x = pack(px);
    new_rho_y = pack(py);
    write_mem = 1'b1;
    @(negedge clk);
    write_mem = 1'b0;
    checks++; if (field !== exp_mid) begin errors++; $display("FAIL merge_field got %h expected %h", field, exp_mid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL merge_busy got %b expected 1", busy); end
    cycles = 1;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      if (busy === 1'b1) cycles++;
      if (inject && cycles == 3) begin
        new_rho_x = {4{WD'(9)}};
        new_rho_y = '0;
        write_mem = 1'b1;
      end else write_mem = 1'b0;
    end
    write_mem = 1'b0;
    checks++; if (cycles != H + 2*k) begin errors++; $display("FAIL busy_cycles got %0d expected %0d", cycles, H + 2*k); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b expected 1", done); end
    checks++; if (lines_cleared !== 3'(k)) begin errors++; $display("FAIL lines_cleared got %0d expected %0d", lines_cleared, k); end
    checks++; if (total_lines !== SW'(m_total)) begin errors++; $display("FAIL total_lines got %0d expected %0d", total_lines, m_total); end
    checks++; if (overlap !== m_overlap) begin errors++; $display("FAIL overlap got %b expected %b", overlap, m_overlap); end
    checks++; if (field !== model_field()) begin errors++; $display("FAIL final_field got %h expected %h", field, model_field()); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b expected 0", done); end
  endtask

  task automatic fill_rows_and_drop();
    int n;
    n = 0;
    for (int r = 2; r <= 5; r++)
      for (int c = 1; c < W; c++) begin
        px[n] = c; py[n] = r; n++;
        if (n == 4) begin do_merge(0); n = 0; end
      end
    set_piece(0, 2, 0, 3, 0, 4, 0, 5);
    do_merge(0);
    checks++; if (lines_cleared !== 3'd4) begin errors++; $display("FAIL four_lines got %0d expected 4", lines_cleared); end
    checks++; if (field !== '0) begin errors++; $display("FAIL four_empty got %h expected 0", field); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (field !== '0) begin errors++; $display("FAIL rst_field got %h expected 0", field); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", done); end
    checks++; if (lines_cleared !== 3'd0) begin errors++; $display("FAIL rst_lines got %0d expected 0", lines_cleared); end
    checks++; if (total_lines !== '0) begin errors++; $display("FAIL rst_total got %0d expected 0", total_lines); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL rst_overlap got %b expected 0", overlap); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_merge();
    do_clear();
    set_piece(0, 5, 1, 5, 2, 5, 3, 5);
    do_merge(0);
  endtask

  task automatic test_single_clear();
    do_clear();
    set_piece(2, 4, 7, 4, 7, 4, 7, 4);
    do_merge(0);
    set_piece(4, 5, 5, 5, 6, 5, 7, 5);
    do_merge(0);
    set_piece(8, 5, 9, 5, 9, 5, 9, 5);
    do_merge(0);
    set_piece(0, 5, 1, 5, 2, 5, 3, 5);
    do_merge(0);
  endtask

  task automatic test_four_clear_and_saturation();
    do_clear();
    fill_rows_and_drop();
    checks++; if (total_lines !== SW'(4)) begin errors++; $display("FAIL total_four got %0d expected 4", total_lines); end
    fill_rows_and_drop();
    checks++; if (total_lines !== SW'(SAT)) begin errors++; $display("FAIL total_sat got %0d expected %0d", total_lines, SAT); end
  endtask

  task automatic test_collision();
    bit exp;
    do_clear();
    set_piece(2, 5, 3, 5, 4, 5, 5, 5);
    do_merge(0);
    for (int t = 0; t < 24; t++) begin
      case (t)
        0: begin qx = '{10, 0, 0, 0}; qy = '{0, 0, 0, 0}; exp = 1; end
        1: begin qx = '{0, 1, 2, 3};  qy = '{0, 0, 6, 0}; exp = 1; end
        2: begin qx = '{0, 1, 2, 3};  qy = '{0, 0, 0, 0}; exp = 0; end
        3: begin qx = '{0, 1, 3, 9};  qy = '{4, 4, 5, 0}; exp = 1; end
        default: begin
          for (int c = 0; c < 4; c++) begin qx[c] = $urandom_range(0, 10); qy[c] = $urandom_range(3, 6); end
          exp = model_collision();
        end
      endcase
      @(negedge clk);
      qry_rho_x = pack(qx);
      qry_rho_y = pack(qy);
      #1;
      checks++; if (collision !== exp) begin errors++; $display("FAIL collision_%0d got %b expected %b", t, collision, exp); end
    end
  endtask

  task automatic test_overlap();
    do_clear();
    set_piece(3, 3, 3, 3, 3, 3, 3, 3);
    do_merge(0);
    set_piece(3, 3, 4, 3, 5, 3, 6, 3);
    do_merge(0);
    set_piece(0, 0, 1, 0, 2, 0, 3, 0);
    do_merge(0);
    do_clear();
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL clr_overlap got %b expected 0", overlap); end
    checks++; if (field !== '0) begin errors++; $display("FAIL clr_field got %h expected 0", field); end
  endtask

  task automatic test_busy_ignore();
    do_clear();
    set_piece(0, 1, 1, 1, 2, 1, 3, 1);
    do_merge(1);
  endtask

  task automatic test_rst_in_shift();
    logic [SIZE-1:0] mid;
    int k;
    do_clear();
    set_piece(4, 5, 5, 5, 6, 5, 7, 5);
    do_merge(0);
    set_piece(8, 5, 9, 5, 7, 5, 7, 5);
    do_merge(0);
    set_piece(0, 5, 1, 5, 2, 5, 3, 5);
    model_apply(mid, k);
    @(negedge clk);
    new_rho_x = pack(px);
    new_rho_y = pack(py);
    write_mem = 1'b1;
    @(negedge clk);
    write_mem = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shift_busy got %b expected 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (field !== '0) begin errors++; $display("FAIL arst_field got %h expected 0", field); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b expected 0", busy); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL arst_overlap got %b expected 0", overlap); end
    checks++; if (lines_cleared !== 3'd0 || done !== 1'b0 || total_lines !== '0) begin
      errors++; $display("FAIL arst_counts got lines %0d done %b total %0d expected 0 0 0", lines_cleared, done, total_lines);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clear_in_scan();
    bit seen;
    do_clear();
    @(negedge clk);
    new_rho_x = pack('{0, 1, 2, 3});
    new_rho_y = pack('{2, 2, 2, 2});
    write_mem = 1'b1;
    @(negedge clk);
    write_mem = 1'b0;
    @(negedge clk);
    clear_field = 1'b1;
    @(negedge clk);
    clear_field = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scanclr_busy got %b expected 0", busy); end
    checks++; if (field !== '0) begin errors++; $display("FAIL scanclr_field got %h expected 0", field); end
    seen = (done === 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL scanclr_done got 1 expected 0"); end
    model_reset();
  endtask

  task automatic test_random();
    do_clear();
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 4; c++) begin
        px[c] = $urandom_range(0, 10);
        py[c] = $urandom_range(2, 6);
      end
      do_merge(0);
      for (int c = 0; c < 4; c++) begin qx[c] = $urandom_range(0, 10); qy[c] = $urandom_range(0, 6); end
      qry_rho_x = pack(qx);
      qry_rho_y = pack(qy);
      #1;
      checks++; if (collision !== model_collision()) begin
        errors++; $display("FAIL rand_collision got %b expected %b", collision, model_collision());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_merge();
    test_single_clear();
    test_four_clear_and_saturation();
    test_collision();
    test_overlap();
    test_busy_ignore();
    test_rst_in_shift();
    test_clear_in_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
